pcs_link_ctrl: RTL and testbench

//  Bring-up and link supervisor for the 10GBASE-R PCS datapath (encoder, scrambler/descrambler,
//  TX/RX gearboxes, block-lock FSM). Sequences datapath reset and init_done, waits for RX block

---
 rtl/pcs_ctrl_pkg.sv | 25 ++
 rtl/pcs_ber_monitor.sv | 59 +++++
 rtl/pcs_link_ctrl.sv | 144 ++++++++++++++
 tb/tb_pcs_link_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pcs_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pcs_ctrl_pkg
// Purpose : Shared link-state encoding and sync-header helpers for the
//           10GBASE-R PCS link controller.
// Revision: 1.0 - initial release
// ============================================================================
package pcs_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        INIT   = 2'd1,
        STABLE = 2'd2,
        UP     = 2'd3
    } link_state_t;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    function automatic logic is_valid_header(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcs_ber_monitor.sv
`default_nettype none
// ============================================================================
// Module  : pcs_ber_monitor
// Purpose : Windowed sync-header error monitor producing the hi_ber flag.
// Revision: 1.0 - initial release
// ============================================================================
module pcs_ber_monitor
    import pcs_ctrl_pkg::*;
#(
    parameter int BER_WINDOW = 1024,
    parameter int BER_THRESH = 16
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_enable,
    input  logic       i_rx_valid,
    input  logic [1:0] i_rx_header,
    output logic       o_hi_ber,
    output logic       o_err_pulse
);

    localparam int c_WIN_W = $clog2(BER_WINDOW + 1);

    logic [c_WIN_W-1:0] r_win_cnt;
    logic [c_WIN_W-1:0] r_err_cnt;
    logic               r_hi_ber;
    logic [c_WIN_W-1:0] w_err_next;
    logic               w_bad;
    logic               w_win_end;

    assign w_bad       = i_enable && i_rx_valid && !is_valid_header(i_rx_header);
    assign w_err_next  = r_err_cnt + c_WIN_W'(w_bad);
    assign w_win_end   = (r_win_cnt == c_WIN_W'(BER_WINDOW - 1));
    assign o_err_pulse = w_bad;
    assign o_hi_ber    = r_hi_ber;

    // The closing header of a window is folded into that window's verdict.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || !i_enable) begin
            r_win_cnt <= '0;
            r_err_cnt <= '0;
            r_hi_ber  <= 1'b0;
        end else if (i_rx_valid) begin
            if (w_win_end) begin
                r_win_cnt <= '0;
                r_err_cnt <= '0;
                r_hi_ber  <= (w_err_next >= c_WIN_W'(BER_THRESH));
            end else begin
                r_win_cnt <= r_win_cnt + 1'b1;
                r_err_cnt <= w_err_next;
                if (w_err_next >= c_WIN_W'(BER_THRESH)) begin
                    r_hi_ber <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pcs_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pcs_link_ctrl
// Purpose : Per-lane PCS bring-up sequencer, lock supervisor and link-up gate.
// Revision: 1.0 - initial release
// ============================================================================
module pcs_link_ctrl
    import pcs_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int LINK_STABLE   = 256,
    parameter int BER_WINDOW    = 1024,
    parameter int BER_THRESH    = 16,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_restart,
    input  logic                     i_block_lock,
    input  logic                     i_rx_valid,
    input  logic [1:0]               i_rx_header,
    input  logic                     i_err_clear,
    output logic                     o_pcs_reset,
    output logic                     o_init_done,
    output logic                     o_hi_ber,
    output logic                     o_link_up,
    output logic [ERR_CNT_WIDTH-1:0] o_err_count
);

    localparam int c_HOLD_W = $clog2(RESET_CYCLES + 1);
    localparam int c_LOCK_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int c_STAB_W = $clog2(LINK_STABLE + 1);

    link_state_t             r_state;
    link_state_t             w_state_next;
    logic [c_HOLD_W-1:0]     r_hold_cnt,  w_hold_cnt_next;
    logic [c_LOCK_W-1:0]     r_lock_tmr,  w_lock_tmr_next;
    logic [c_STAB_W-1:0]     r_stab_cnt,  w_stab_cnt_next;
    logic                    r_pcs_reset;
    logic                    r_init_done;
    logic                    r_link_up;
    logic [ERR_CNT_WIDTH-1:0] r_err_count;
    logic                    w_hi_ber;
    logic                    w_err_pulse;

    pcs_ber_monitor #(
        .BER_WINDOW (BER_WINDOW),
        .BER_THRESH (BER_THRESH)
    ) u_ber_monitor (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_enable    (i_block_lock),
        .i_rx_valid  (i_rx_valid),
        .i_rx_header (i_rx_header),
        .o_hi_ber    (w_hi_ber),
        .o_err_pulse (w_err_pulse)
    );

    // Counters default to zero so every state change starts its timer fresh.
    always_comb begin
        w_state_next    = r_state;
        w_hold_cnt_next = '0;
        w_lock_tmr_next = '0;
        w_stab_cnt_next = '0;
        case (r_state)
            HOLD: begin
                if (r_hold_cnt == c_HOLD_W'(RESET_CYCLES - 1)) begin
                    w_state_next = INIT;
                end else begin
                    w_hold_cnt_next = r_hold_cnt + 1'b1;
                end
            end
            INIT: begin
                if (i_block_lock) begin
                    w_state_next = STABLE;
                end else if (r_lock_tmr == c_LOCK_W'(LOCK_TIMEOUT - 1)) begin
                    w_state_next = HOLD;
                end else begin
                    w_lock_tmr_next = r_lock_tmr + 1'b1;
                end
            end
            STABLE: begin
                if (!i_block_lock) begin
                    w_state_next = INIT;
                end else if (!w_hi_ber) begin
                    if (r_stab_cnt == c_STAB_W'(LINK_STABLE - 1)) begin
                        w_state_next = UP;
                    end else begin
                        w_stab_cnt_next = r_stab_cnt + 1'b1;
                    end
                end
            end
            UP: begin
                if (!i_block_lock) begin
                    w_state_next = INIT;
                end else if (w_hi_ber) begin
                    w_state_next = STABLE;
                end
            end
            default: w_state_next = HOLD;
        endcase
        if (i_restart) begin
            w_state_next    = HOLD;
            w_hold_cnt_next = '0;
            w_lock_tmr_next = '0;
            w_stab_cnt_next = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= HOLD;
            r_hold_cnt  <= '0;
            r_lock_tmr  <= '0;
            r_stab_cnt  <= '0;
            r_pcs_reset <= 1'b1;
            r_init_done <= 1'b0;
            r_link_up   <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_hold_cnt  <= w_hold_cnt_next;
            r_lock_tmr  <= w_lock_tmr_next;
            r_stab_cnt  <= w_stab_cnt_next;
            r_pcs_reset <= (w_state_next == HOLD);
            r_init_done <= (w_state_next != HOLD);
            r_link_up   <= (w_state_next == UP);
            if (i_err_clear) begin
                r_err_count <= '0;
            end else if (w_err_pulse && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign o_pcs_reset = r_pcs_reset;
    assign o_init_done = r_init_done;
    assign o_hi_ber    = w_hi_ber;
    assign o_link_up   = r_link_up;
    assign o_err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_pcs_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pcs_link_ctrl
// Purpose : Directed self-checking bench for pcs_link_ctrl (default build plus
//           a 4-bit error-counter build).
// Revision: 1.0 - initial release
// ============================================================================
module tb_pcs_link_ctrl;

    logic        clk = 1'b0;
    int          errors = 0;
    int          checks = 0;
    int          a_hdrs = 0;

    logic        a_reset_n, a_restart, a_lock, a_valid, a_err_clear;
    logic [1:0]  a_hdr;
    logic        a_pcs_reset, a_init_done, a_hi_ber, a_link_up;
    logic [15:0] a_err_count;

    logic        b_reset_n, b_restart, b_lock, b_valid, b_err_clear;
    logic [1:0]  b_hdr;
    logic        b_pcs_reset, b_init_done, b_hi_ber, b_link_up;
    logic [3:0]  b_err_count;

    always #5 clk = ~clk;

    pcs_link_ctrl u_dut_a (
        .i_clk        (clk),
        .i_reset_n    (a_reset_n),
        .i_restart    (a_restart),
        .i_block_lock (a_lock),
        .i_rx_valid   (a_valid),
        .i_rx_header  (a_hdr),
        .i_err_clear  (a_err_clear),
        .o_pcs_reset  (a_pcs_reset),
        .o_init_done  (a_init_done),
        .o_hi_ber     (a_hi_ber),
        .o_link_up    (a_link_up),
        .o_err_count  (a_err_count)
    );

    pcs_link_ctrl #(.ERR_CNT_WIDTH(4)) u_dut_b (
        .i_clk        (clk),
        .i_reset_n    (b_reset_n),
        .i_restart    (b_restart),
        .i_block_lock (b_lock),
        .i_rx_valid   (b_valid),
        .i_rx_header  (b_hdr),
        .i_err_clear  (b_err_clear),
        .o_pcs_reset  (b_pcs_reset),
        .o_init_done  (b_init_done),
        .o_hi_ber     (b_hi_ber),
        .o_link_up    (b_link_up),
        .o_err_count  (b_err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; tracks how many headers instance A's BER window has absorbed.
    task automatic step();
        if (!a_reset_n || !a_lock) a_hdrs = 0;
        else if (a_valid)          a_hdrs++;
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        a_reset_n = 1'b0; a_restart = 1'b0; a_lock = 1'b0; a_valid = 1'b0;
        a_err_clear = 1'b0; a_hdr = 2'b01;
        b_reset_n = 1'b0; b_restart = 1'b0; b_lock = 1'b0; b_valid = 1'b0;
        b_err_clear = 1'b0; b_hdr = 2'b01;
        steps(3);

        // Test 1: bring-up sequence, lock at cycle 40, link-up at 297
        a_reset_n = 1'b1; a_valid = 1'b1;
        chk("t1_rst_pcs_reset", a_pcs_reset, 1);
        chk("t1_rst_init_done", a_init_done, 0);
        chk("t1_rst_link_up",   a_link_up,   0);
        chk("t1_rst_hi_ber",    a_hi_ber,    0);
        chk("t1_rst_err_count", a_err_count, 0);
        for (int c = 1; c <= 15; c++) begin
            step();
            chk("t1_hold_pcs_reset", a_pcs_reset, 1);
        end
        step();
        chk("t1_c16_pcs_reset", a_pcs_reset, 0);
        chk("t1_c16_init_done", a_init_done, 1);
        steps(24);
        a_lock = 1'b1;
        steps(256);
        chk("t1_c296_link_up", a_link_up, 0);
        step();
        chk("t1_c297_link_up", a_link_up, 1);

        // Test 4: 15 invalid headers in one window stay below threshold
        a_hdr = 2'b00; steps(8);
        a_hdr = 2'b11; steps(7);
        a_hdr = 2'b01;
        step();
        chk("t4_hi_ber",    a_hi_ber,    0);
        chk("t4_err_count", a_err_count, 15);
        chk("t4_link_up",   a_link_up,   1);
        while (a_hdrs % 1024 != 0) step();
        chk("t4_win_end_hi_ber", a_hi_ber, 0);

        // Test 3: 16 invalid headers trip hi_ber, clean window recovers
        a_hdr = 2'b00; steps(15);
        chk("t3_15th_hi_ber", a_hi_ber, 0);
        step();
        chk("t3_16th_hi_ber",  a_hi_ber,  1);
        chk("t3_16th_link_up", a_link_up, 1);
        a_hdr = 2'b10;
        step();
        chk("t3_link_drop",  a_link_up,   0);
        chk("t3_err_count",  a_err_count, 31);
        while (a_hdrs % 1024 != 0) step();
        chk("t3_bad_win_end_hi_ber", a_hi_ber, 1);
        steps(1023);
        chk("t3_clean_pre_end_hi_ber", a_hi_ber, 1);
        step();
        chk("t3_clean_end_hi_ber", a_hi_ber, 0);
        steps(255);
        chk("t3_relink_early", a_link_up, 0);
        step();
        chk("t3_relink", a_link_up, 1);

        // Test 5: one-cycle lock loss clears window and drops the link
        a_hdr = 2'b00; steps(10);
        a_hdr = 2'b01;
        a_lock = 1'b0;
        step();
        chk("t5_link_up",   a_link_up,   0);
        chk("t5_hi_ber",    a_hi_ber,    0);
        chk("t5_init_done", a_init_done, 1);
        chk("t5_pcs_reset", a_pcs_reset, 0);
        a_lock = 1'b1;
        a_hdr = 2'b11; steps(6);
        a_hdr = 2'b01;
        chk("t5_window_cleared", a_hi_ber,    0);
        chk("t5_err_count",      a_err_count, 47);
        steps(250);
        chk("t5_relink_early", a_link_up, 0);
        step();
        chk("t5_relink", a_link_up, 1);

        // Test 2: no lock -> timeout restart through HOLD
        a_reset_n = 1'b0; a_lock = 1'b0;
        step();
        a_reset_n = 1'b1;
        steps(16);
        chk("t2_init_entry", a_init_done, 1);
        steps(65535);
        chk("t2_pre_timeout_pcs_reset", a_pcs_reset, 0);
        chk("t2_pre_timeout_init_done", a_init_done, 1);
        step();
        chk("t2_timeout_pcs_reset", a_pcs_reset, 1);
        chk("t2_timeout_init_done", a_init_done, 0);
        steps(15);
        chk("t2_hold_last_pcs_reset", a_pcs_reset, 1);
        step();
        chk("t2_reinit_pcs_reset", a_pcs_reset, 0);
        chk("t2_reinit_init_done", a_init_done, 1);

        // Test 6: 4-bit error counter, restart, saturation and clear priority
        b_reset_n = 1'b1; b_lock = 1'b1; b_valid = 1'b1;
        steps(272);
        chk("t6_link_up_early", b_link_up, 0);
        step();
        chk("t6_link_up", b_link_up, 1);
        b_restart = 1'b1;
        step();
        b_restart = 1'b0;
        chk("t6_restart_pcs_reset", b_pcs_reset, 1);
        chk("t6_restart_link_up",   b_link_up,   0);
        chk("t6_restart_init_done", b_init_done, 0);
        b_hdr = 2'b00;
        steps(15);
        chk("t6_err_15", b_err_count, 15);
        steps(5);
        chk("t6_err_sat", b_err_count, 15);
        b_err_clear = 1'b1;
        step();
        b_err_clear = 1'b0;
        chk("t6_clear_wins", b_err_count, 0);
        step();
        chk("t6_count_after_clear", b_err_count, 1);
        b_hdr = 2'b01;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
